// File: rtl/demux1_to_4_32_buf.sv
// demux1_to_4_32_buf: 1-to-4 word distributor with a one-entry valid/ready buffer
// and a wrapping delivered-word counter per channel.
module demux1_to_4_32_buf #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s1,
    input  logic             s0,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1,
    output logic [CNTW-1:0]  cnt2,
    output logic [CNTW-1:0]  cnt3
);
    logic [1:0]       sel;
    logic [3:0]       acc;
    logic [WIDTH-1:0] data_q [4];
    logic [CNTW-1:0]  cnt_q [4];

    assign sel      = {s1, s0};
    assign in_ready = ~out_valid[sel] | out_ready[sel];

    always_comb begin
        acc      = '0;
        acc[sel] = in_valid & in_ready;
    end

    // A channel stays valid if refilled this edge or still waiting on its consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc[k]) data_q[k] <= in_data;
                if (out_valid[k] & out_ready[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
                out_valid[k] <= acc[k] | (out_valid[k] & ~out_ready[k]);
            end
        end
    end

    assign o0   = data_q[0];
    assign o1   = data_q[1];
    assign o2   = data_q[2];
    assign o3   = data_q[3];
    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
endmodule

// File: tb/tb_demux1_to_4_32_buf.sv
// tb_demux1_to_4_32_buf: directed vector table plus hand sequences for async reset
// and long streaming with counter wrap.
module tb_demux1_to_4_32_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        s1 = 1'b0, s0 = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] o0, o1, o2, o3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;
    int          total = 0, bad = 0;

    demux1_to_4_32_buf dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .s1(s1), .s0(s0),
        .in_valid(in_valid), .in_ready(in_ready),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] din;
        logic        vin;
        logic [3:0]  ordy;
        logic        ir;
        logic [3:0]  ov;
        logic [1:0]  ch;
        logic [31:0] od;
        logic [7:0]  oc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] get_o(input logic [1:0] i);
        return i == 2'd0 ? o0 : i == 2'd1 ? o1 : i == 2'd2 ? o2 : o3;
    endfunction

    function automatic logic [7:0] get_cnt(input logic [1:0] i);
        return i == 2'd0 ? cnt0 : i == 2'd1 ? cnt1 : i == 2'd2 ? cnt2 : cnt3;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        {s1, s0}  = v.sel;
        in_data   = v.din;
        in_valid  = v.vin;
        out_ready = v.ordy;
        #1 chk("in_ready", idx, {31'd0, in_ready}, {31'd0, v.ir});
        @(posedge clk);
        #1;
        chk("out_valid", idx, {28'd0, out_valid}, {28'd0, v.ov});
        chk("o", idx, get_o(v.ch), v.od);
        chk("cnt", idx, {24'd0, get_cnt(v.ch)}, {24'd0, v.oc});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{2'd1, 32'h12345678, 1'b1, 4'b0000, 1'b1, 4'b0010, 2'd1, 32'h12345678, 8'd0});
        tbl.push_back('{2'd1, 32'h00000000, 1'b0, 4'b0000, 1'b0, 4'b0010, 2'd1, 32'h12345678, 8'd0});
        tbl.push_back('{2'd0, 32'h00000000, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1, 32'h12345678, 8'd0});
        tbl.push_back('{2'd3, 32'h11110000, 1'b1, 4'b0000, 1'b1, 4'b1010, 2'd3, 32'h11110000, 8'd0});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{2'd3, 32'hAAAA5555, 1'b1, 4'b0000, 1'b0, 4'b1010, 2'd3, 32'h11110000, 8'd0});
        tbl.push_back('{2'd3, 32'hAAAA5555, 1'b1, 4'b1000, 1'b1, 4'b1010, 2'd3, 32'hAAAA5555, 8'd1});
        tbl.push_back('{2'd0, 32'h00000000, 1'b0, 4'b0010, 1'b1, 4'b1000, 2'd1, 32'h12345678, 8'd1});
        tbl.push_back('{2'd0, 32'h00000000, 1'b0, 4'b0001, 1'b1, 4'b1000, 2'd0, 32'h00000000, 8'd0});
        tbl.push_back('{2'd0, 32'h00000C0C, 1'b1, 4'b0000, 1'b1, 4'b1001, 2'd0, 32'h00000C0C, 8'd0});
        tbl.push_back('{2'd2, 32'h0000FFFF, 1'b1, 4'b0001, 1'b1, 4'b1100, 2'd2, 32'h0000FFFF, 8'd0});
        tbl.push_back('{2'd0, 32'h00000000, 1'b0, 4'b0000, 1'b1, 4'b1100, 2'd0, 32'h00000C0C, 8'd1});
        tbl.push_back('{2'd0, 32'h00000000, 1'b0, 4'b0100, 1'b1, 4'b1000, 2'd2, 32'h0000FFFF, 8'd1});
        tbl.push_back('{2'd1, 32'h0BADBEEF, 1'b1, 4'b0000, 1'b1, 4'b1010, 2'd1, 32'h0BADBEEF, 8'd1});
        tbl.push_back('{2'd1, 32'hCAFEF00D, 1'b1, 4'b0000, 1'b0, 4'b1010, 2'd1, 32'h0BADBEEF, 8'd1});
        tbl.push_back('{2'd2, 32'hCAFEF00D, 1'b1, 4'b0000, 1'b1, 4'b1110, 2'd2, 32'hCAFEF00D, 8'd1});
        tbl.push_back('{2'd0, 32'h00000000, 1'b0, 4'b0000, 1'b1, 4'b1110, 2'd1, 32'h0BADBEEF, 8'd1});
        tbl.push_back('{2'd2, 32'hDEADBEEF, 1'b1, 4'b0100, 1'b1, 4'b1110, 2'd2, 32'hDEADBEEF, 8'd2});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, {28'd0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("rst_o", k, get_o(2'(k)), 32'd0);
            chk("rst_cnt", k, {24'd0, get_cnt(2'(k))}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

        // Mid-cycle async reset with channel 2 holding DEADBEEF and channel 3 counted.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = '0;
        @(posedge clk);
        #3;
        chk("pre_rst_o2", 0, o2, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 0, {28'd0, out_valid}, 32'd0);
        chk("async_o2", 0, o2, 32'd0);
        chk("async_o3", 0, o3, 32'd0);
        chk("async_cnt", 0, {cnt0, cnt1, cnt2, cnt3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream of 1..300 on channel 0 with consumer always ready.
        {s1, s0}  = 2'd0;
        out_ready = 4'b0001;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            in_data  = k;
            in_valid = 1'b1;
            #1 chk("stream_ready", k, {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk("stream_o0", k, o0, k);
            chk("stream_cnt0", k, {24'd0, cnt0}, (k - 1) % 256);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_final_cnt0", 0, {24'd0, cnt0}, 32'd44);
        chk("stream_final_valid", 0, {28'd0, out_valid}, 32'd0);
        chk("stream_final_o0", 0, o0, 32'd300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
